// File: rtl/mux_b.sv
// Operand-B source selector: picks a, b or c onto the ALU B bus under a 2-bit select,
// with a registered copy of the result and a sticky illegal-select flag.
module mux_b #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       s,
    input  logic             en,
    input  logic             clr_err,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] d_q,
    output logic             sel_err
);

    logic             sel_illegal;
    logic [WIDTH-1:0] d_q_d;
    logic [WIDTH-1:0] d_q_q;
    logic             sel_err_d;
    logic             sel_err_q;

    assign sel_illegal = (s == 2'b11);

    // Select 11 drives zeros so the bus is always defined.
    always_comb begin
        d = '0;
        case (s)
            2'b00:   d = a;
            2'b01:   d = b;
            2'b10:   d = c;
            default: d = '0;
        endcase
    end

    always_comb begin
        d_q_d = d_q_q;
        if (en) begin
            d_q_d = d;
        end
    end

    // Setting has priority over a simultaneous clear.
    always_comb begin
        sel_err_d = sel_err_q;
        if (sel_illegal) begin
            sel_err_d = 1'b1;
        end else if (clr_err) begin
            sel_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            d_q_q     <= d_q_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign d_q     = d_q_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_b.sv
// Self-checking bench for mux_b: vector table for the combinational select, hand-written
// register/flag/reset sequences, and randomized stimulus against a behavioural model.
module tb_mux_b;

    logic        clk;
    logic        rst;
    logic [15:0] a, b, c;
    logic [1:0]  s;
    logic        en;
    logic        clr_err;
    logic [15:0] d;
    logic [15:0] d_q;
    logic        sel_err;

    int total;
    int bad;

    mux_b #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .c       (c),
        .s       (s),
        .en      (en),
        .clr_err (clr_err),
        .d       (d),
        .d_q     (d_q),
        .sel_err (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  s;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [15:0] exp_d;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: sources indexed by select, slot 3 is the zero constant.
    function automatic logic [15:0] ref_d(input logic [1:0] sel, input logic [15:0] ra,
                                          input logic [15:0] rb, input logic [15:0] rc);
        logic [15:0] src[4];
        src[0] = ra;
        src[1] = rb;
        src[2] = rc;
        src[3] = 16'h0000;
        return src[sel];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] m_dq;
        logic        m_err;
        logic [15:0] exp_d;

        total = 0;
        bad   = 0;
        rst = 1'b1; a = '0; b = '0; c = '0; s = 2'b00; en = 1'b1; clr_err = 1'b0;

        vecs[0] = '{"sel_a",      2'b00, 16'h1234, 16'h4321, 16'hABCD, 16'h1234};
        vecs[1] = '{"sel_b",      2'b01, 16'h1234, 16'h4321, 16'hABCD, 16'h4321};
        vecs[2] = '{"sel_c",      2'b10, 16'h1234, 16'h4321, 16'hABCD, 16'hABCD};
        vecs[3] = '{"sel_zero",   2'b11, 16'h1234, 16'h4321, 16'hABCD, 16'h0000};
        vecs[4] = '{"b_change",   2'b01, 16'h1234, 16'h00FF, 16'hABCD, 16'h00FF};
        vecs[5] = '{"a_change",   2'b01, 16'hFFFF, 16'h00FF, 16'hABCD, 16'h00FF};
        vecs[6] = '{"c_change",   2'b01, 16'hFFFF, 16'h00FF, 16'h5555, 16'h00FF};
        vecs[7] = '{"sel_c_ones", 2'b10, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};

        // Combinational table under reset: d must still follow inputs, registers stay clear.
        #2;
        check("rst_d_q", d_q, 16'h0000);
        check("rst_sel_err", {15'd0, sel_err}, 16'h0000);
        foreach (vecs[i]) begin
            s = vecs[i].s; a = vecs[i].a; b = vecs[i].b; c = vecs[i].c;
            #1;
            check(vecs[i].name, d, vecs[i].exp_d);
            #9;
        end
        check("rst_hold_d_q", d_q, 16'h0000);
        check("rst_hold_sel_err", {15'd0, sel_err}, 16'h0000);

        // Registered path.
        @(negedge clk);
        rst = 1'b0; a = 16'h1234; b = 16'h4321; c = 16'hABCD; s = 2'b10; en = 1'b1;
        @(posedge clk); #1;
        check("load_d_q", d_q, 16'hABCD);
        @(negedge clk);
        s = 2'b00; en = 1'b0;
        @(posedge clk); #1;
        check("hold_d_q", d_q, 16'hABCD);
        check("no_err", {15'd0, sel_err}, 16'h0000);

        // Illegal select: sticky flag, clear, set-wins.
        @(negedge clk); s = 2'b11;
        @(posedge clk); #1;
        check("err_set", {15'd0, sel_err}, 16'h0001);
        check("err_hold_d_q_en0", d_q, 16'hABCD);
        @(negedge clk); s = 2'b00;
        @(posedge clk); #1;
        check("err_sticky", {15'd0, sel_err}, 16'h0001);
        @(negedge clk); clr_err = 1'b1;
        @(posedge clk); #1;
        check("err_clear", {15'd0, sel_err}, 16'h0000);
        @(negedge clk); s = 2'b11;
        @(posedge clk); #1;
        check("err_set_wins", {15'd0, sel_err}, 16'h0001);
        @(negedge clk); clr_err = 1'b0; s = 2'b10;

        // Async reset between edges.
        @(posedge clk); #3;
        check("pre_rst_d_q", d_q, 16'hABCD);
        check("pre_rst_err", {15'd0, sel_err}, 16'h0001);
        rst = 1'b1;
        #1;
        check("async_d_q", d_q, 16'h0000);
        check("async_err", {15'd0, sel_err}, 16'h0000);
        check("async_d_tracks", d, 16'hABCD);
        s = 2'b01;
        #1;
        check("async_d_tracks_b", d, 16'h4321);
        @(negedge clk);
        rst = 1'b0; en = 1'b1; s = 2'b00;
        @(posedge clk); #1;
        check("first_load", d_q, 16'h1234);

        // Randomized run against the model.
        m_dq  = 16'h1234;
        m_err = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
            s = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 3) != 0);
            clr_err = ($urandom_range(0, 3) == 0);
            #1;
            exp_d = ref_d(s, a, b, c);
            check("rnd_d", d, exp_d);
            if (en) m_dq = exp_d;
            if (s == 2'b11) m_err = 1'b1;
            else if (clr_err) m_err = 1'b0;
            @(posedge clk); #1;
            check("rnd_d_q", d_q, m_dq);
            check("rnd_sel_err", {15'd0, sel_err}, {15'd0, m_err});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
